// File: rtl/kodd_dmem_pkg.sv
// Shared address-map constants and decode types for the kodd data memory / MMIO block.
package kodd_dmem_pkg;

  // MMIO register offsets within the 256-byte MMIO page
  localparam logic [7:0] CYCLE_OFS  = 8'h00;
  localparam logic [7:0] TXDATA_OFS = 8'h04;
  localparam logic [7:0] STATUS_OFS = 8'h08;
  localparam logic [7:0] CTRL_OFS   = 8'h0C;

  // STATUS bit positions
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 8;

  // CTRL bit positions
  localparam int CTRL_CLR_OVF_BIT   = 0;
  localparam int CTRL_CLR_CYCLE_BIT = 1;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_e;

endpackage

// File: rtl/kodd_sync_fifo.sv
// Synchronous FIFO, combinational head output (0 while empty), one write and one read per cycle.
// The caller decides push acceptance; a push while full is only legal together with a pop.
module kodd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign doPop   = pop && !empty;
  assign popData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kodd_dmem.sv
// Data RAM + MMIO (cycle counter, TX FIFO) behind the core M stage; ReadDataM is zero-latency.
// No stall path: TX pushes into a full FIFO without a same-cycle pop are dropped and flag overflow.
module kodd_dmem
  import kodd_dmem_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  region_e           region;
  logic [7:0]        ofs;
  logic [RAM_AW-1:0] ramIdx;
  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       cycleCnt;
  logic              overflow;
  logic              mmioWr;
  logic              txPush;
  logic              ctrlWr;
  logic              pushOk;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CW-1:0]     fifoCount;
  logic [31:0]       statusWord;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^ALUOutM[1:0];

  // Byte lanes are ignored: everything decodes on the word address.
  assign ofs    = {ALUOutM[7:2], 2'b00};
  assign ramIdx = ALUOutM[RAM_AW+1:2];

  always_comb begin
    region = REGION_NONE;
    if (ALUOutM[31:RAM_AW+2] == '0) begin
      region = REGION_RAM;
    end else if (ALUOutM[31:8] == MMIO_BASE[31:8]) begin
      region = REGION_MMIO;
    end
  end

  assign mmioWr  = MemWriteM && (region == REGION_MMIO);
  assign txPush  = mmioWr && (ofs == TXDATA_OFS);
  assign ctrlWr  = mmioWr && (ofs == CTRL_OFS);
  assign fifoPop = tx_valid && tx_ready;
  assign pushOk  = txPush && (!fifoFull || fifoPop);
  assign tx_valid = !fifoEmpty;

  always_ff @(posedge clk) begin
    if (MemWriteM && (region == REGION_RAM)) begin
      ram[ramIdx] <= WriteDataM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCnt <= '0;
    end else if (ctrlWr && WriteDataM[CTRL_CLR_CYCLE_BIT]) begin
      cycleCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
    end
  end

  // A dropped push outranks a same-cycle clear so the loss is never hidden.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (txPush && !pushOk) begin
      overflow <= 1'b1;
    end else if (ctrlWr && WriteDataM[CTRL_CLR_OVF_BIT]) begin
      overflow <= 1'b0;
    end
  end

  kodd_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) uTxFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushOk),
    .pushData (WriteDataM[7:0]),
    .pop      (fifoPop),
    .popData  (tx_data),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_comb begin
    statusWord = '0;
    statusWord[STATUS_EMPTY_BIT] = fifoEmpty;
    statusWord[STATUS_FULL_BIT]  = fifoFull;
    statusWord[STATUS_OVF_BIT]   = overflow;
    statusWord[STATUS_COUNT_LSB +: CW] = fifoCount;
  end

  always_comb begin
    ReadDataM = '0;
    case (region)
      REGION_RAM: ReadDataM = ram[ramIdx];
      REGION_MMIO: begin
        case (ofs)
          CYCLE_OFS:  ReadDataM = cycleCnt;
          STATUS_OFS: ReadDataM = statusWord;
          default:    ReadDataM = '0;
        endcase
      end
      default: ReadDataM = '0;
    endcase
  end

endmodule
